// File: rtl/wb_initiator_if.sv
// Bundle of the command, response and Wishbone classic signals around wb_initiator.
// The master modport is the initiator's view. The slave modport is the environment's view.
interface wb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator. It runs one read or write per command.
// A bounded ack timeout reports rsp_err instead of hanging.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 16
) (
  input  logic                clk,
  input  logic                reset,
  wb_initiator_if.master      bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 32'd1);

  state_t        state_r, state_s;
  logic          cyc_r, cyc_s;
  logic          we_r, we_s;
  logic [3:0]    sel_r, sel_s;
  logic [31:0]   adr_r, adr_s;
  logic [31:0]   wdat_r, wdat_s;
  logic          rsp_valid_r, rsp_valid_s;
  logic [31:0]   rsp_dat_r, rsp_dat_s;
  logic          rsp_err_r, rsp_err_s;
  logic [CW-1:0] cnt_r, cnt_s;

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    cyc_s       = cyc_r;
    we_s        = we_r;
    sel_s       = sel_r;
    adr_s       = adr_r;
    wdat_s      = wdat_r;
    rsp_valid_s = rsp_valid_r;
    rsp_dat_s   = rsp_dat_r;
    rsp_err_s   = rsp_err_r;
    cnt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          we_s    = bus.cmd_we;
          sel_s   = bus.cmd_sel;
          adr_s   = bus.cmd_adr;
          wdat_s  = bus.cmd_dat;
          cyc_s   = 1'b1;
          cnt_s   = '0;
          state_s = BUS;
        end else begin
          cyc_s   = 1'b0;
        end
      end
      BUS: begin
        // An ack on the limit edge wins over the timeout
        if (bus.wbm_ack_i) begin
          cyc_s       = 1'b0;
          rsp_dat_s   = we_r ? 32'h0000_0000 : bus.wbm_dat_i;
          rsp_err_s   = 1'b0;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else if (cnt_r == LIMIT) begin
          cyc_s       = 1'b0;
          rsp_dat_s   = 32'h0000_0000;
          rsp_err_s   = 1'b1;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else begin
          cnt_s       = cnt_r + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        cyc_s       = 1'b0;
        rsp_valid_s = 1'b0;
        cnt_s       = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= 4'h0;
      adr_r       <= 32'h0000_0000;
      wdat_r      <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_s;
      cyc_r       <= cyc_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      adr_r       <= adr_s;
      wdat_r      <= wdat_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_dat_r   <= rsp_dat_s;
      rsp_err_r   <= rsp_err_s;
      cnt_r       <= cnt_s;
    end
  end

  assign bus.cmd_ready = (state_r == IDLE);
  assign busy          = (state_r != IDLE);
  assign bus.wbm_cyc_o = cyc_r;
  assign bus.wbm_stb_o = cyc_r;
  assign bus.wbm_we_o  = we_r;
  assign bus.wbm_sel_o = sel_r;
  assign bus.wbm_adr_o = adr_r;
  assign bus.wbm_dat_o = wdat_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_dat   = rsp_dat_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator. It uses a transaction-level model checked every cycle.
// It adds hand-computed checks on pulse lengths, data and handshake timing.
module tb_wb_initiator;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  logic busy;
  wb_initiator_if bus ();

  wb_initiator #(.TIMEOUT(TIMEOUT), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int tests = 0;
  int fails = 0;

  // slave behaviour knobs
  int          ack_delay = -1;
  bit          cnt_mode  = 1'b0;
  logic [31:0] const_dat = 32'h0;
  bit          spur      = 1'b0;
  int          stb_cnt   = 0;
  int          last_pulse = 0;
  logic [31:0] ack_val   = 32'h0;
  logic [31:0] slave_cnt = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // counter slave: free-running count cleared by reset
  always @(posedge clk) slave_cnt <= reset ? 32'h0 : slave_cnt + 32'h1;

  // Wishbone slave and strobe-pulse monitor, acting on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (bus.wbm_cyc_o === 1'b1 && bus.wbm_stb_o === 1'b1) begin
        stb_cnt++;
        if (ack_delay >= 0 && stb_cnt == ack_delay + 1) begin
          ack_val       = cnt_mode ? slave_cnt : const_dat;
          bus.wbm_dat_i = ack_val;
          bus.wbm_ack_i = 1'b1;
        end else begin
          bus.wbm_ack_i = 1'b0;
        end
      end else begin
        if (stb_cnt > 0) last_pulse = stb_cnt;
        stb_cnt       = 0;
        bus.wbm_ack_i = spur;
      end
    end
  end

  // transaction-level model and per-cycle compare
  bit          m_known = 1'b0;
  bit          m_stb = 1'b0, m_rv = 1'b0, m_err = 1'b0, m_we = 1'b0;
  int          m_age = 0;
  logic [31:0] m_rdat = 32'h0, m_adr = 32'h0, m_wdat = 32'h0;
  logic [3:0]  m_sel = 4'h0;
  logic [106:0] act_v, exp_v;
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_known = 1'b1; m_stb = 1'b0; m_rv = 1'b0; m_err = 1'b0; m_we = 1'b0;
        m_age = 0; m_rdat = 32'h0; m_adr = 32'h0; m_wdat = 32'h0; m_sel = 4'h0;
      end else if (m_rv) begin
        if (bus.rsp_ready) m_rv = 1'b0;
      end else if (m_stb) begin
        m_age++;
        if (bus.wbm_ack_i) begin
          m_stb = 1'b0; m_rv = 1'b1; m_err = 1'b0;
          m_rdat = m_we ? 32'h0 : bus.wbm_dat_i;
        end else if (m_age == TIMEOUT) begin
          m_stb = 1'b0; m_rv = 1'b1; m_err = 1'b1; m_rdat = 32'h0;
        end
      end else if (bus.cmd_valid) begin
        m_we = bus.cmd_we; m_adr = bus.cmd_adr; m_wdat = bus.cmd_dat; m_sel = bus.cmd_sel;
        m_stb = 1'b1; m_age = 0;
      end
      #1;
      if (m_known) begin
        act_v = {bus.cmd_ready, busy, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.rsp_valid,
                 bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o,
                 bus.rsp_valid ? {bus.rsp_err, bus.rsp_dat} : 33'h0};
        exp_v = {!(m_stb || m_rv), (m_stb || m_rv), m_stb, m_stb, m_we, m_rv,
                 m_sel, m_adr, m_wdat, m_rv ? {m_err, m_rdat} : 33'h0};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL cycle@%0t: got %h, expected %h", $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    bit ok;
    ok = 1'b0;
    step();
    bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL cmd_accept: got cmd_ready=0, expected 1 within 50 cycles");
    end
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output logic [31:0] d, output logic e);
    bit ok;
    ok = 1'b0;
    d = 32'hDEAD_DEAD;
    e = 1'bx;
    for (int i = 0; i < max; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        d = bus.rsp_dat;
        e = bus.rsp_err;
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rsp_wait: got no rsp_valid, expected one within %0d cycles", max);
    end
  endtask

  logic [31:0] rd;
  logic        re;

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = 32'h0; bus.cmd_dat = 32'h0;
    bus.cmd_sel = 4'h0; bus.rsp_ready = 1'b1; bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = 32'h0;
    repeat (3) step();
    chk("reset_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    chk("reset_adr", bus.wbm_adr_o, 32'h0);
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_ready", {30'h0, bus.cmd_ready, busy}, 32'h2);

    // write, slave acks 2 cycles after stb
    ack_delay = 2; cnt_mode = 1'b0; const_dat = 32'hFFFF_FFFF;
    do_cmd(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF);
    chk("wr_dat_o", bus.wbm_dat_o, 32'h1234_5678);
    chk("wr_we_o", {31'h0, bus.wbm_we_o}, 32'h1);
    wait_rsp(40, rd, re);
    chk("wr_rsp_dat", rd, 32'h0);
    chk("wr_rsp_err", {31'h0, re}, 32'h0);
    step();
    chk("wr_pulse", last_pulse, 32'd3);

    // read from counter slave, immediate ack
    ack_delay = 0; cnt_mode = 1'b1;
    do_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    wait_rsp(40, rd, re);
    chk("cnt_rsp_dat", rd, ack_val);
    chk("cnt_rsp_err", {31'h0, re}, 32'h0);
    step();
    chk("cnt_pulse", last_pulse, 32'd1);

    // timeout: slave never acks
    ack_delay = -1; cnt_mode = 1'b0;
    do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    wait_rsp(60, rd, re);
    chk("to_rsp_dat", rd, 32'h0);
    chk("to_rsp_err", {31'h0, re}, 32'h1);
    step();
    chk("to_pulse", last_pulse, 32'd16);

    // ack on the same edge as the timeout limit counts as success
    ack_delay = TIMEOUT - 1; const_dat = 32'h0BAD_BEEF;
    do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    wait_rsp(60, rd, re);
    chk("lim_rsp_err", {31'h0, re}, 32'h0);
    chk("lim_rsp_dat", rd, 32'h0BAD_BEEF);
    step();
    chk("lim_pulse", last_pulse, 32'd16);

    // backpressure with a queued command waiting
    bus.rsp_ready = 1'b0; ack_delay = 1; const_dat = 32'hCAFE_F00D;
    do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp(40, rd, re);
    ack_delay = 0;
    bus.cmd_we = 1'b1; bus.cmd_adr = 32'h3000_000C; bus.cmd_dat = 32'hA5A5_A5A5;
    bus.cmd_sel = 4'h3; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_dat[29:0]},
          {1'b1, 1'b0, 30'h0AFE_F00D});
      chk("bp_dat", bus.rsp_dat, 32'hCAFE_F00D);
      step();
    end
    bus.rsp_ready = 1'b1;
    chk("bp_ready_same", {31'h0, bus.cmd_ready}, 32'h0);
    step();
    chk("bp_ready_next", {30'h0, bus.cmd_ready, bus.rsp_valid}, 32'h2);
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_accept", {31'h0, busy}, 32'h1);
    wait_rsp(40, rd, re);
    chk("bp_wr_rsp", rd, 32'h0);
    step();

    // spurious ack while idle
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) begin
      step();
      chk("spur_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end

    // reset two cycles into the strobe
    ack_delay = -1;
    do_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    step();
    chk("rst_mid_stb", {31'h0, bus.wbm_stb_o}, 32'h1);
    reset = 1'b1;
    step();
    chk("rst_mid_cyc", {30'h0, bus.wbm_cyc_o, bus.rsp_valid}, 32'h0);
    reset = 1'b0;
    step();
    chk("rst_mid_ready", {30'h0, bus.cmd_ready, bus.rsp_valid}, 32'h2);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
